// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle fetch/execute control unit for ALU-class instructions.
// Build option: define ALU_SEQ_RETIRE_CNT_EN to add the retired_cnt counter output.
module alu_op_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic              mem_rdy,
  input  logic [31:0]       ir,
  output logic              pc_out,
  output logic              mar_in,
  output logic              z_in,
  output logic              zlow_out,
  output logic              zhigh_out,
  output logic              pc_in,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              read,
  output logic              ir_in,
  output logic              y_in,
  output logic              gra,
  output logic              grb,
  output logic              grc,
  output logic              r_in,
  output logic              r_out,
  output logic              hi_in,
  output logic              lo_in,
  output logic [13:0]       alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              fault
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_cnt
`endif
);

  localparam int unsigned ALU_W  = 14;
  localparam int unsigned WAIT_W = ($clog2(MEM_WAIT_MAX + 1) > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  localparam logic [ALU_W-1:0] ALU_ADD   = 14'h0001;
  localparam logic [ALU_W-1:0] ALU_SUB   = 14'h0002;
  localparam logic [ALU_W-1:0] ALU_MUL   = 14'h0004;
  localparam logic [ALU_W-1:0] ALU_DIV   = 14'h0008;
  localparam logic [ALU_W-1:0] ALU_AND   = 14'h0010;
  localparam logic [ALU_W-1:0] ALU_OR    = 14'h0020;
  localparam logic [ALU_W-1:0] ALU_SHR   = 14'h0040;
  localparam logic [ALU_W-1:0] ALU_SHRA  = 14'h0080;
  localparam logic [ALU_W-1:0] ALU_SHL   = 14'h0100;
  localparam logic [ALU_W-1:0] ALU_ROR   = 14'h0200;
  localparam logic [ALU_W-1:0] ALU_ROL   = 14'h0400;
  localparam logic [ALU_W-1:0] ALU_NEG   = 14'h0800;
  localparam logic [ALU_W-1:0] ALU_NOT   = 14'h1000;
  localparam logic [ALU_W-1:0] ALU_INCPC = 14'h2000;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [1:0] {C_BAD, C_3REG, C_2REG, C_HILO} op_class_t;

  state_t           state;
  logic [WAIT_W-1:0] wait_cnt;
  op_class_t        op_class;
  logic [ALU_W-1:0] op_strobe;
  logic [4:0]       opcode;
  logic             unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Opcode to instruction class and its ALU strobe
  always_comb begin
    op_class  = C_BAD;
    op_strobe = '0;
    case (opcode)
      5'b00011: begin op_class = C_3REG; op_strobe = ALU_ADD;  end
      5'b00100: begin op_class = C_3REG; op_strobe = ALU_SUB;  end
      5'b01010: begin op_class = C_3REG; op_strobe = ALU_AND;  end
      5'b01011: begin op_class = C_3REG; op_strobe = ALU_OR;   end
      5'b00101: begin op_class = C_3REG; op_strobe = ALU_SHR;  end
      5'b00110: begin op_class = C_3REG; op_strobe = ALU_SHRA; end
      5'b00111: begin op_class = C_3REG; op_strobe = ALU_SHL;  end
      5'b01000: begin op_class = C_3REG; op_strobe = ALU_ROR;  end
      5'b01001: begin op_class = C_3REG; op_strobe = ALU_ROL;  end
      5'b10001: begin op_class = C_2REG; op_strobe = ALU_NEG;  end
      5'b10010: begin op_class = C_2REG; op_strobe = ALU_NOT;  end
      5'b01111: begin op_class = C_HILO; op_strobe = ALU_MUL;  end
      5'b10000: begin op_class = C_HILO; op_strobe = ALU_DIV;  end
      default:  ;
    endcase
  end

  // State register and fetch wait counter; run is only sampled in IDLE and the done state
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1: begin
          if (mem_rdy)                               state <= S_T2;
          else if (wait_cnt == WAIT_W'(MEM_WAIT_MAX)) state <= S_FAULT;
          else                                       wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_T2:   state <= S_T3;
        S_T3:   state <= (op_class == C_BAD) ? S_HALT : S_T4;
        S_T4: begin
          if (op_class == C_2REG) state <= run ? S_T0 : S_IDLE;
          else                    state <= S_T5;
        end
        S_T5: begin
          if (op_class == C_HILO) state <= S_T6;
          else                    state <= run ? S_T0 : S_IDLE;
        end
        S_T6:    state <= run ? S_T0 : S_IDLE;
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of state and opcode; mdr_in additionally qualifies on mem_rdy
  always_comb begin
    pc_out = 1'b0; mar_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0;
    pc_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0; ir_in = 1'b0; y_in = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    alu_op  = '0;
    done    = 1'b0;
    busy    = !(state inside {S_IDLE, S_HALT, S_FAULT});
    illegal = (state == S_HALT);
    fault   = (state == S_FAULT);
    case (state)
      S_T0: begin pc_out = 1'b1; mar_in = 1'b1; alu_op = ALU_INCPC; z_in = 1'b1; end
      S_T1: begin
        zlow_out = 1'b1;
        read     = 1'b1;
        pc_in    = (wait_cnt == '0);
        mdr_in   = mem_rdy;
      end
      S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: begin
        case (op_class)
          C_3REG:  begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
          C_2REG:  begin grb = 1'b1; r_out = 1'b1; alu_op = op_strobe; z_in = 1'b1; end
          C_HILO:  begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_3REG:  begin grc = 1'b1; r_out = 1'b1; alu_op = op_strobe; z_in = 1'b1; end
          C_2REG:  begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; done = 1'b1; end
          C_HILO:  begin grb = 1'b1; r_out = 1'b1; alu_op = op_strobe; z_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_HILO:  begin zlow_out = 1'b1; lo_in = 1'b1; end
          default: begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; done = 1'b1; end
        endcase
      end
      S_T6: begin zhigh_out = 1'b1; hi_in = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  // Retired-instruction count, wraps naturally
  always_ff @(posedge clock or posedge clear) begin
    if (clear)     retired_cnt <= '0;
    else if (done) retired_cnt <= retired_cnt + CNT_W'(1);
  end
`endif

endmodule
